icache_fill_unit: RTL and testbench
===================================

Name: icache_fill_unit

Overview:
Direct-mapped L1 instruction cache with a single-miss fill engine. It sits directly upstream of the memory controller.
- Serves 32-bit instruction fetches from the core front end.
- On a miss, issues a line-aligned 256-bit block read request to the memory controller.
- Consumes the returned block, writes it into the line array, and completes the stalled fetch.

Parameters:
- numLines, 32: cache lines; power of two; index width = log2(numLines).
- addressWidth, 64: fetch and memory address width.
- blockWidth, 256: line size in bits (8 instruction words, 32 bytes).
- instructionWidth, 32: fetched word width.

Ports:
- clock_i  in  1  core clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- fetchAddress_i  in  64  byte address of the instruction; bit 0 = MSB.
- fetchEnable_i  in  1  fetch request; sampled only while stall_o = 0.
- instruction_o  out  32  fetched word.
- instructionValid_o  out  1  one-cycle pulse; instruction_o is valid.
- stall_o  out  1  unit busy; front end holds off new fetches.
- invalidateAll_i  in  1  clears every valid bit.
- memAddress_o  out  64  line-aligned request address; low 5 bits = 0.
- memData_o  out  256  write data; tied to 0.
- memRequestEnable_o  out  1  one-cycle request strobe.
- memIsWrite_o  out  1  tied to 0; the unit only reads.
- block_i  in  256  returned block.
- blockAddress_i  in  64  address of the returned block.
- blockOutEnable_i  in  1  block_i / blockAddress_i valid this cycle.
- isMemoryEngaged_i  in  1  memory controller busy; no new request accepted.

Behaviour:
- Address split: offset = bits 59:63; word select = bits 59:61; bits 62:63 ignored; index = bits 54:58 (numLines = 32); tag = bits 0:53.
- Word k of a line = line bits [32k : 32k+31]. Word 0 is the lowest address.
- Storage: per line, valid bit, 54-bit tag and 256-bit data. All valid bits are cleared by reset.
- Reset (reset_i = 0 at an edge) produces the following state:
  - FSM in IDLE; all valid bits = 0.
  - Outputs: instruction_o = 0, instructionValid_o = 0, stall_o = 0, memRequestEnable_o = 0, memAddress_o = 0.
- FSM states:
  - IDLE:
    - fetchEnable_i = 1 and hit: at the next edge instruction_o = selected word and instructionValid_o = 1. Hit latency is 1 cycle; back-to-back hits run one per cycle.
    - fetchEnable_i = 1 and miss: latch the fetch address, set stall_o = 1, go to REQ.
  - REQ:
    - Wait while isMemoryEngaged_i = 1.
    - When isMemoryEngaged_i = 0, drive memAddress_o = latched address with bits 59:63 = 0 and memRequestEnable_o = 1 for exactly one cycle, then go to WAIT.
  - WAIT:
    - Accept a return only when blockOutEnable_i = 1 and blockAddress_i = memAddress_o. A mismatched return is ignored.
    - On accept: write data and tag, set valid, go to RESP.
  - RESP: instruction_o = selected word from the captured block, instructionValid_o = 1, stall_o = 0, go to IDLE. Miss-to-data latency = memory latency + 2 cycles.
- Fetches presented while stall_o = 1 are ignored. The front end re-presents the fetch after the stalled fetch completes.
- invalidateAll_i:
  - Clears all valid bits at the next edge, in any state.
  - A hit lookup in the same cycle sees the pre-invalidate state.
  - If asserted during REQ or WAIT, the in-flight fill still delivers the instruction, but that line is NOT marked valid.
- Reset mid-fill drops the fill. A block returned after reset is ignored because the FSM is in IDLE.
- blockOutEnable_i in IDLE or REQ is ignored.

Optional Feature:
- Macro: ICACHE_PERF_COUNTERS_EN.
- When defined, adds two outputs:
  - hitCount_o (32): increments on every IDLE hit that produces instructionValid_o.
  - missCount_o (32): increments on every IDLE-to-REQ transition.
- Both counters saturate at 0xFFFFFFFF and are cleared by reset; they are unaffected by invalidateAll_i.
- When undefined, neither port nor any counter logic exists.

Test Plan:
- Cold miss: after reset, fetch 0x308 with the model returning block FFFFFFFF_EEEEEEEE_..._88888888 for 0x300. Expect:
  - one request strobe with memAddress_o = 0x300;
  - instruction_o = DDDDDDDD at RESP;
  - stall_o high from the edge after the fetch until RESP.
- Hit after fill: fetch 0x31C, then 0x300. Expect 88888888 then FFFFFFFF on consecutive cycles, each one cycle after its fetch, with no request strobe.
- Conflict miss: fetch 0x1308 (same index 24, different tag). Expect a request for 0x1300, after which fetch 0x308 misses again.
- Busy controller: hold isMemoryEngaged_i = 1 for 5 cycles during REQ. Expect no strobe until it drops, then exactly one strobe.
- Wrong-address return: in WAIT, pulse blockOutEnable_i with blockAddress_i = 0x400. Expect it ignored and the unit still waiting; the correct return then completes the fetch.
- invalidateAll_i during WAIT: the fill completes and returns the word, and a refetch of the same address misses. Reset during WAIT followed by a late block return: expect the unit to stay in IDLE and instructionValid_o to stay 0.

Source files
------------

// File: rtl/icache_fill_unit.sv
// Direct-mapped instruction cache with a single outstanding line fill toward the memory controller.
// Optional hit/miss counters are compiled in when ICACHE_PERF_COUNTERS_EN is defined.
module icache_fill_unit #(
   parameter int numLines         = 32,
   parameter int addressWidth     = 64,
   parameter int blockWidth       = 256,
   parameter int instructionWidth = 32
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic [addressWidth-1:0]     fetchAddress_i,
   input  logic                        fetchEnable_i,
   output logic [instructionWidth-1:0] instruction_o,
   output logic                        instructionValid_o,
   output logic                        stall_o,
   input  logic                        invalidateAll_i,
   output logic [addressWidth-1:0]     memAddress_o,
   output logic [blockWidth-1:0]       memData_o,
   output logic                        memRequestEnable_o,
   output logic                        memIsWrite_o,
   input  logic [blockWidth-1:0]       block_i,
   input  logic [addressWidth-1:0]     blockAddress_i,
   input  logic                        blockOutEnable_i,
   input  logic                        isMemoryEngaged_i
`ifdef ICACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0]                 hitCount_o,
   output logic [31:0]                 missCount_o
`endif
);

   localparam int indexWidth   = $clog2(numLines);
   localparam int offsetWidth  = $clog2(blockWidth / 8);
   localparam int tagWidth     = addressWidth - indexWidth - offsetWidth;
   localparam int wordsPerLine = blockWidth / instructionWidth;
   localparam int wordSelWidth = $clog2(wordsPerLine);
   localparam int byteSelWidth = offsetWidth - wordSelWidth;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t state, nextState;

   logic [numLines-1:0]   validBits;
   logic [tagWidth-1:0]   tagArray  [numLines];
   logic [blockWidth-1:0] dataArray [numLines];

   logic [addressWidth-1:byteSelWidth] missAddress;
   logic                               dropValid;
   logic lookupHit, startMiss, issueReq, acceptFill;

   logic [indexWidth-1:0]   fetchIndex, fillIndex;
   logic [tagWidth-1:0]     fetchTag, fillTag;
   logic [wordSelWidth-1:0] fetchWord, fillWord;
   logic                    unusedByteSel;

   assign fetchIndex    = fetchAddress_i[offsetWidth +: indexWidth];
   assign fetchTag      = fetchAddress_i[addressWidth-1 -: tagWidth];
   assign fetchWord     = fetchAddress_i[byteSelWidth +: wordSelWidth];
   assign fillIndex     = missAddress[offsetWidth +: indexWidth];
   assign fillTag       = missAddress[addressWidth-1 -: tagWidth];
   assign fillWord      = missAddress[byteSelWidth +: wordSelWidth];
   assign unusedByteSel = ^fetchAddress_i[byteSelWidth-1:0];

   assign stall_o      = (state != IDLE);
   assign memData_o    = '0;
   assign memIsWrite_o = 1'b0;

   // Word 0 sits in the most significant bits of the line, so word k is slot ~k of the packed view.
   function automatic logic [instructionWidth-1:0] pickWord(input logic [blockWidth-1:0] line,
                                                           input logic [wordSelWidth-1:0] sel);
      logic [wordsPerLine-1:0][instructionWidth-1:0] words;
      words = line;
      return words[~sel];
   endfunction

   always_ff @(posedge clock_i) begin
      if (!reset_i) state <= IDLE;
      else          state <= nextState;
   end

   always_comb begin
      nextState  = state;
      lookupHit  = 1'b0;
      startMiss  = 1'b0;
      issueReq   = 1'b0;
      acceptFill = 1'b0;
      case (state)
         IDLE: if (fetchEnable_i) begin
            if (validBits[fetchIndex] && tagArray[fetchIndex] == fetchTag) begin
               lookupHit = 1'b1;
            end else begin
               startMiss = 1'b1;
               nextState = REQ;
            end
         end
         REQ: if (!isMemoryEngaged_i) begin
            issueReq  = 1'b1;
            nextState = WAIT;
         end
         WAIT: if (blockOutEnable_i && blockAddress_i == memAddress_o) begin
            acceptFill = 1'b1;
            nextState  = RESP;
         end
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         validBits          <= '0;
         instruction_o      <= '0;
         instructionValid_o <= 1'b0;
         memRequestEnable_o <= 1'b0;
         memAddress_o       <= '0;
         missAddress        <= '0;
         dropValid          <= 1'b0;
      end else begin
         instructionValid_o <= 1'b0;
         memRequestEnable_o <= issueReq;
         if (lookupHit) begin
            instruction_o      <= pickWord(dataArray[fetchIndex], fetchWord);
            instructionValid_o <= 1'b1;
         end
         if (state == RESP) begin
            instruction_o      <= pickWord(dataArray[fillIndex], fillWord);
            instructionValid_o <= 1'b1;
         end
         if (startMiss) begin
            missAddress <= fetchAddress_i[addressWidth-1:byteSelWidth];
            dropValid   <= 1'b0;
         end
         if (issueReq)
            memAddress_o <= {missAddress[addressWidth-1:offsetWidth], {offsetWidth{1'b0}}};
         // A flush seen while the fill is outstanding keeps that line from being marked valid.
         if (invalidateAll_i && (state == REQ || state == WAIT))
            dropValid <= 1'b1;
         if (invalidateAll_i)
            validBits <= '0;
         else if (acceptFill && !dropValid)
            validBits[fillIndex] <= 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i && acceptFill) begin
         tagArray[fillIndex]  <= fillTag;
         dataArray[fillIndex] <= block_i;
      end
   end

`ifdef ICACHE_PERF_COUNTERS_EN
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         hitCount_o  <= '0;
         missCount_o <= '0;
      end else begin
         if (lookupHit && hitCount_o != '1)  hitCount_o  <= hitCount_o + 32'd1;
         if (startMiss && missCount_o != '1) missCount_o <= missCount_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_fill_unit.sv
// Randomized bench for icache_fill_unit: the bench plays the memory controller and predicts
// hits/misses and fetched words from a line-level model of the cache and of memory contents.
module tb_icache_fill_unit;

   logic         clk = 1'b0;
   logic         rstN;
   logic [63:0]  fetchAddress;
   logic         fetchEnable;
   logic [31:0]  instruction;
   logic         instructionValid;
   logic         stall;
   logic         invalidateAll;
   logic [63:0]  memAddress;
   logic [255:0] memData;
   logic         memRequestEnable;
   logic         memIsWrite;
   logic [255:0] blockData;
   logic [63:0]  blockAddress;
   logic         blockOutEnable;
   logic         memEngaged;

   int total = 0;
   int bad   = 0;

   logic [31:0] mValid;
   logic [53:0] mTag [32];

   always #5 clk = ~clk;

   icache_fill_unit dut (
      .clock_i(clk), .reset_i(rstN),
      .fetchAddress_i(fetchAddress), .fetchEnable_i(fetchEnable),
      .instruction_o(instruction), .instructionValid_o(instructionValid), .stall_o(stall),
      .invalidateAll_i(invalidateAll),
      .memAddress_o(memAddress), .memData_o(memData),
      .memRequestEnable_o(memRequestEnable), .memIsWrite_o(memIsWrite),
      .block_i(blockData), .blockAddress_i(blockAddress), .blockOutEnable_i(blockOutEnable),
      .isMemoryEngaged_i(memEngaged)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory image: line 0x300 holds the descending FFFFFFFF..88888888 pattern, others a hash.
   function automatic logic [31:0] wordFor(input logic [63:0] line, input logic [2:0] k);
      if (line == 64'h300) return 32'hFFFF_FFFF - 32'(k) * 32'h1111_1111;
      return (line[31:0] * 32'h0001_0003) ^ ((32'(k) + 32'd1) * 32'h9E37_79B9);
   endfunction

   function automatic logic [255:0] blockFor(input logic [63:0] line);
      logic [255:0] b;
      for (int j = 0; j < 8; j++) b[255-32*j -: 32] = wordFor(line, 3'(j));
      return b;
   endfunction

   task automatic hardReset();
      rstN = 1'b0; fetchEnable = 1'b0; invalidateAll = 1'b0;
      blockOutEnable = 1'b0; memEngaged = 1'b0;
      step();
      rstN = 1'b1;
      mValid = '0;
   endtask

   task automatic doFetch(input logic [63:0] addr, input int busy, input bit badRet,
                          input bit invMid, input bit invWithFetch);
      logic [63:0] line, badAddr;
      logic [4:0]  idx;
      logic [53:0] tag;
      logic [2:0]  k;
      bit          expHit, seen;
      int          strobes;
      line = {addr[63:5], 5'b0};
      idx  = addr[9:5];
      tag  = addr[63:10];
      k    = addr[4:2];
      expHit = mValid[idx] && (mTag[idx] == tag);
      chk("idleStall", 64'(stall), 64'd0);
      fetchAddress = addr; fetchEnable = 1'b1; invalidateAll = invWithFetch;
      memEngaged = (busy > 0);
      step();
      fetchEnable = 1'b0; invalidateAll = 1'b0;
      if (invWithFetch) mValid = '0;
      if (expHit) begin
         chk("hitValid", 64'(instructionValid), 64'd1);
         chk("hitData", 64'(instruction), 64'(wordFor(line, k)));
         chk("hitNoReq", 64'(memRequestEnable), 64'd0);
         chk("hitNoStall", 64'(stall), 64'd0);
      end else begin
         chk("missStall", 64'(stall), 64'd1);
         chk("missNoValid", 64'(instructionValid), 64'd0);
         strobes = 0;
         // Stray fetches during the stall must be ignored.
         fetchEnable = 1'($urandom_range(0, 1));
         fetchAddress = {52'($urandom), 12'($urandom)};
         for (int i = 0; i < busy; i++) begin
            step();
            strobes += int'(memRequestEnable);
         end
         if (busy > 0) chk("busyNoReq", 64'(strobes), 64'd0);
         memEngaged = 1'b0;
         seen = 1'b0;
         for (int n = 0; n < 20 && !seen; n++) begin
            step();
            seen = memRequestEnable;
         end
         chk("reqSeen", 64'(seen), 64'd1);
         if (!seen) begin
            hardReset();
            return;
         end
         chk("reqAddr", memAddress, line);
         strobes = 0;
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            step();
            strobes += int'(memRequestEnable);
         end
         if (badRet) begin
            badAddr = (line == 64'h400) ? 64'h800 : 64'h400;
            blockOutEnable = 1'b1; blockAddress = badAddr; blockData = blockFor(badAddr);
            step();
            blockOutEnable = 1'b0;
            strobes += int'(memRequestEnable);
            step();
            chk("badRetStall", 64'(stall), 64'd1);
            chk("badRetNoValid", 64'(instructionValid), 64'd0);
         end
         if (invMid) begin
            invalidateAll = 1'b1;
            step();
            invalidateAll = 1'b0;
            strobes += int'(memRequestEnable);
            mValid = '0;
         end
         blockOutEnable = 1'b1; blockAddress = line; blockData = blockFor(line);
         step();
         blockOutEnable = 1'b0; blockData = {8{$urandom}};
         strobes += int'(memRequestEnable);
         seen = 1'b0;
         for (int n = 0; n < 4 && !seen; n++) begin
            if (!instructionValid) chk("fillStall", 64'(stall), 64'd1);
            step();
            strobes += int'(memRequestEnable);
            seen = instructionValid;
         end
         fetchEnable = 1'b0;
         chk("fillValid", 64'(seen), 64'd1);
         chk("fillData", 64'(instruction), 64'(wordFor(line, k)));
         chk("fillStallDrop", 64'(stall), 64'd0);
         chk("singleReq", 64'(strobes), 64'd0);
         if (!invMid) begin
            mValid[idx] = 1'b1;
            mTag[idx]   = tag;
         end
      end
      memEngaged = 1'b0;
   endtask

   initial begin
      logic [63:0] a;
      bit ok;
      fetchAddress = '0; blockData = '0; blockAddress = '0;
      hardReset();
      rstN = 1'b0;
      step();
      chk("rstInstr", 64'(instruction), 64'd0);
      chk("rstValid", 64'(instructionValid), 64'd0);
      chk("rstStall", 64'(stall), 64'd0);
      chk("rstReq", 64'(memRequestEnable), 64'd0);
      chk("rstAddr", memAddress, 64'd0);
      chk("memIsWrite", 64'(memIsWrite), 64'd0);
      chk("memDataZero", 64'(memData != '0), 64'd0);
      rstN = 1'b1;
      step();

      doFetch(64'h308, 0, 0, 0, 0);               // cold miss -> DDDDDDDD
      chk("coldWord", 64'(instruction), 64'hDDDD_DDDD);
      doFetch(64'h31C, 0, 0, 0, 0);               // hit -> 88888888
      doFetch(64'h300, 0, 0, 0, 0);               // hit -> FFFFFFFF
      doFetch(64'h1308, 0, 0, 0, 0);              // conflict miss at index 24
      doFetch(64'h308, 0, 0, 0, 0);               // evicted -> misses again
      doFetch(64'h1308, 5, 0, 0, 0);              // busy controller for 5 cycles
      doFetch(64'h308, 0, 1, 0, 0);               // wrong-address return first
      doFetch(64'h1308, 0, 0, 1, 0);              // invalidate during WAIT
      doFetch(64'h1308, 0, 0, 0, 0);              // so this misses
      doFetch(64'h1308, 0, 0, 0, 1);              // hit sees pre-invalidate state
      doFetch(64'h1310, 0, 0, 0, 0);              // then misses

      // Reset while waiting for the block, then a late return.
      fetchAddress = 64'h5308; fetchEnable = 1'b1;
      step();
      fetchEnable = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         step();
         ok = memRequestEnable;
      end
      chk("midRstReq", 64'(ok), 64'd1);
      rstN = 1'b0;
      step();
      rstN = 1'b1;
      mValid = '0;
      chk("midRstStall", 64'(stall), 64'd0);
      chk("midRstAddr", memAddress, 64'd0);
      blockOutEnable = 1'b1; blockAddress = 64'h5300; blockData = blockFor(64'h5300);
      step();
      blockOutEnable = 1'b0;
      ok = 1'b1;
      for (int n = 0; n < 4; n++) begin
         if (instructionValid || stall) ok = 1'b0;
         step();
      end
      chk("lateReturnIgnored", 64'(ok), 64'd1);
      doFetch(64'h5308, 0, 0, 0, 0);

      for (int r = 0; r < 150; r++) begin
         a = {50'($urandom_range(0, 2)), 4'd0, 5'($urandom_range(0, 7)), 3'($urandom), 2'($urandom)};
         doFetch(a, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
